// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port program/data memory between the CPU and an external host port.
// The host is granted only after the CPU has been frozen and drained, and the CPU's read data is refetched on release.
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int DRAIN_CYCLES = 2,
  parameter int HOST_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  input  logic              host_req,
  output logic              host_gnt,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_timeout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_CPU     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_HOST    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(HOST_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        drain_cnt_q, drain_cnt_d;
  logic [7:0]        idle_cnt_q, idle_cnt_d;
  logic              req_armed_q, req_armed_d;
  logic              rd_pend_q, rd_pend_d;
  logic              timeout_q, timeout_d;
  logic              cpu_side_q, cpu_side_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  // Next-state and control
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = '0;
    idle_cnt_d  = '0;
    timeout_d   = 1'b0;
    rd_pend_d   = 1'b0;
    req_armed_d = req_armed_q;
    if (!host_req) begin
      req_armed_d = 1'b1;
    end
    case (state_q)
      ST_CPU: begin
        if (host_req && req_armed_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!host_req) begin
          state_d = ST_RELEASE;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_HOST;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      ST_HOST: begin
        // A read beat issued while the request drops still completes in RELEASE.
        rd_pend_d = host_valid & ~host_we;
        if (!host_req) begin
          state_d = ST_RELEASE;
        end else if (host_valid) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d     = ST_RELEASE;
          timeout_d   = 1'b1;
          req_armed_d = 1'b0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_CPU;
      end
      default: begin
        state_d = ST_CPU;
      end
    endcase
  end

  // Read-data capture: the CPU sees frozen data for the whole hold
  always_comb begin
    cpu_side_d   = (state_q == ST_CPU) || (state_q == ST_RELEASE);
    cpu_rdata_d  = cpu_side_q ? mem_rdata : cpu_rdata_q;
    host_rdata_d = rd_pend_q ? mem_rdata : host_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CPU;
      drain_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      req_armed_q  <= 1'b1;
      rd_pend_q    <= 1'b0;
      timeout_q    <= 1'b0;
      cpu_side_q   <= 1'b1;
      host_rdata_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      req_armed_q  <= req_armed_d;
      rd_pend_q    <= rd_pend_d;
      timeout_q    <= timeout_d;
      cpu_side_q   <= cpu_side_d;
      host_rdata_q <= host_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  // Memory port steering; DRAIN and RELEASE present the CPU address read-only
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    case (state_q)
      ST_CPU: begin
        mem_we = cpu_we;
      end
      ST_HOST: begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        mem_we    = host_valid & host_we;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  always_comb begin
    cpu_hold     = (state_q != ST_CPU);
    host_gnt     = (state_q == ST_HOST);
    host_rvalid  = rd_pend_q;
    host_timeout = timeout_q;
    host_rdata   = rd_pend_q ? mem_rdata : host_rdata_q;
    cpu_rdata    = cpu_side_q ? mem_rdata : cpu_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 256x16 registered-read memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic [15:0] cpu_rdata;
  logic        cpu_hold;
  logic        host_req;
  logic        host_gnt;
  logic        host_valid;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic        host_timeout;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  logic        mem_init;
  logic [15:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(8),
    .DATA_W(16),
    .DRAIN_CYCLES(2),
    .HOST_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata),
    .cpu_hold(cpu_hold),
    .host_req(host_req),
    .host_gnt(host_gnt),
    .host_valid(host_valid),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .host_timeout(host_timeout),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[5]    <= 16'h1234;
      mem_rdata <= 16'h0000;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    host_req = 1'b0; host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    cyc(); cyc();
    rst = 1'b0; mem_init = 1'b0;
    #1;
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_host_timeout", host_timeout, 0);
    chk("rst_host_rdata", host_rdata, 16'h0000);

    // 1: CPU pass-through read then write
    cpu_addr = 8'd5; #1;
    chk("t1_mem_addr_rd", mem_addr, 8'd5);
    chk("t1_mem_we_rd", mem_we, 0);
    cyc();
    cpu_addr = 8'd50; cpu_wdata = 16'hBEEF; cpu_we = 1'b1; #1;
    chk("t1_cpu_rdata", cpu_rdata, 16'h1234);
    chk("t1_mem_we_wr", mem_we, 1);
    chk("t1_mem_addr_wr", mem_addr, 8'd50);
    chk("t1_mem_wdata", mem_wdata, 16'hBEEF);
    chk("t1_cpu_hold", cpu_hold, 0);
    cyc();
    cpu_we = 1'b0; cpu_addr = 8'd5; #1;
    chk("t1_mem50", mem[50], 16'hBEEF);
    chk("t1_host_gnt", host_gnt, 0);

    // 2: request, drain, blocked CPU write
    host_req = 1'b1; #1;
    chk("t2_hold_T", cpu_hold, 0);
    cyc();
    chk("t2_hold_T1", cpu_hold, 1);
    chk("t2_gnt_T1", host_gnt, 0);
    chk("t2_rdata_T1", cpu_rdata, 16'h1234);
    cpu_addr = 8'd60; cpu_wdata = 16'hDEAD; cpu_we = 1'b1; #1;
    chk("t2_drain_mem_we", mem_we, 0);
    chk("t2_drain_mem_addr", mem_addr, 8'd60);
    cyc();
    chk("t2_gnt_T2", host_gnt, 0);
    chk("t2_rdata_T2", cpu_rdata, 16'h1234);
    cyc();
    cpu_we = 1'b0; cpu_addr = 8'd5; #1;
    chk("t2_gnt_T3", host_gnt, 1);
    chk("t2_hold_T3", cpu_hold, 1);
    chk("t2_rdata_T3", cpu_rdata, 16'h1234);
    chk("t2_mem60", mem[60], 16'h0000);

    // 3: program load, readback, release
    host_valid = 1'b1; host_we = 1'b1;
    for (int i = 0; i < 13; i++) begin
      host_addr = 8'(i); host_wdata = 16'hA000 + 16'(i); #1;
      if (i == 0) begin
        chk("t3_mem_we", mem_we, 1);
        chk("t3_mem_addr", mem_addr, 8'd0);
        chk("t3_mem_wdata", mem_wdata, 16'hA000);
      end
      cyc();
    end
    host_we = 1'b0; host_addr = 8'd12; #1;
    chk("t3_rd_mem_we", mem_we, 0);
    cyc();
    host_valid = 1'b0; #1;
    chk("t3_rvalid", host_rvalid, 1);
    chk("t3_rdata", host_rdata, 16'hA00C);
    chk("t3_mem5", mem[5], 16'hA005);
    cyc();
    chk("t3_rvalid_off", host_rvalid, 0);
    chk("t3_rdata_hold", host_rdata, 16'hA00C);
    host_req = 1'b0;
    cyc();
    chk("t3_rel_gnt", host_gnt, 0);
    chk("t3_rel_hold", cpu_hold, 1);
    chk("t3_rel_mem_addr", mem_addr, 8'd5);
    chk("t3_rel_mem_we", mem_we, 0);
    chk("t3_rel_cpu_rdata", cpu_rdata, 16'h1234);
    cyc();
    chk("t3_cpu_hold", cpu_hold, 0);
    chk("t3_cpu_rdata", cpu_rdata, 16'hA005);

    // 4: idle timeout and re-arm
    host_req = 1'b1;
    cyc(); cyc(); cyc();
    chk("t4_gnt", host_gnt, 1);
    cyc(); cyc(); cyc();
    chk("t4_gnt_idle3", host_gnt, 1);
    chk("t4_to_idle3", host_timeout, 0);
    cyc();
    chk("t4_timeout", host_timeout, 1);
    chk("t4_gnt_revoked", host_gnt, 0);
    cyc();
    chk("t4_timeout_pulse", host_timeout, 0);
    chk("t4_unhold", cpu_hold, 0);
    cyc(); cyc(); cyc();
    chk("t4_no_regrant_hold", cpu_hold, 0);
    chk("t4_no_regrant_gnt", host_gnt, 0);
    host_req = 1'b0;
    cyc();
    host_req = 1'b1; #1;
    chk("t4_rearm_hold0", cpu_hold, 0);
    cyc();
    chk("t4_rearm_drain", cpu_hold, 1);
    cyc(); cyc();
    chk("t4_regrant", host_gnt, 1);

    // 5: read beat coincident with request drop
    host_valid = 1'b1; host_we = 1'b0; host_addr = 8'd3; host_req = 1'b0;
    cyc();
    host_valid = 1'b0; #1;
    chk("t5_rvalid_rel", host_rvalid, 1);
    chk("t5_rdata_rel", host_rdata, 16'hA003);
    chk("t5_gnt_rel", host_gnt, 0);
    chk("t5_hold_rel", cpu_hold, 1);
    cyc();
    chk("t5_cpu_hold", cpu_hold, 0);
    chk("t5_rvalid_off", host_rvalid, 0);
    chk("t5_cpu_rdata", cpu_rdata, 16'hA005);
    host_valid = 1'b1; host_we = 1'b1; host_addr = 8'd70; host_wdata = 16'h1111; #1;
    chk("t5_ungranted_we", mem_we, 0);
    cyc();
    host_valid = 1'b0; host_we = 1'b0; #1;
    chk("t5_mem70", mem[70], 16'h0000);
    chk("t5_ungranted_rvalid", host_rvalid, 0);

    // 6: reset during HOST with a read in flight
    host_req = 1'b1;
    cyc(); cyc(); cyc();
    chk("t6_gnt", host_gnt, 1);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 8'd12; rst = 1'b1;
    cyc();
    rst = 1'b0; host_we = 1'b1; host_addr = 8'd80; host_wdata = 16'h2222; #1;
    chk("t6_gnt", host_gnt, 0);
    chk("t6_hold", cpu_hold, 0);
    chk("t6_rvalid", host_rvalid, 0);
    chk("t6_rdata", host_rdata, 16'h0000);
    chk("t6_mem_we", mem_we, 0);
    cyc();
    host_req = 1'b0; host_valid = 1'b0; host_we = 1'b0; #1;
    chk("t6_mem80", mem[80], 16'h0000);
    chk("t6_mem12", mem[12], 16'hA00C);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
